// File: rtl/sy_htif_responder.sv
// sy_htif_responder
// Target-side HTIF endpoint that owns the tohost/fromhost doublewords.
// Each tohost store is decoded into one of three actions:
//   - an exit request, which halts the block
//   - a console putchar, which is buffered in a small FIFO and then acknowledged
//   - an unknown command, which is only acknowledged
// Acknowledgement is written back through fromhost.
module sy_htif_responder #(
    parameter int unsigned     AWTH          = 64,
    parameter logic [AWTH-1:0] TOHOST_ADDR   = AWTH'(64'h8000_1000),
    parameter logic [AWTH-1:0] FROMHOST_ADDR = AWTH'(64'h8000_1040),
    parameter int unsigned     FIFO_DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_vld_i,
    output logic            req_rdy_o,
    input  logic            req_we_i,
    input  logic [AWTH-1:0] req_addr_i,
    input  logic [63:0]     req_wdata_i,
    output logic            rsp_vld_o,
    output logic [63:0]     rsp_rdata_o,
    output logic            con_vld_o,
    output logic [7:0]      con_char_o,
    input  logic            con_rdy_i,
    output logic            halt_o,
    output logic            pass_o,
    output logic [62:0]     exit_code_o
);

    localparam int unsigned    PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CONS,
        ACK,
        HALT
    } state_e;

    state_e          state_q;
    logic [63:0]     tohost_q;
    logic [63:0]     fromhost_q;
    logic            halt_q;
    logic            pass_q;
    logic [62:0]     exit_code_q;
    logic            rsp_vld_q;
    logic [63:0]     rsp_rdata_q;
    logic [63:0]     rsp_rdata_d;
    logic [7:0]      fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]  count_q;
    logic [PTR_W:0]  count_d;

    logic tohostHit;
    logic fromhostHit;
    logic reqAccept;
    logic tohostWrite;
    logic fromhostWrite;
    logic isPutchar;
    logic fifoEmpty;
    logic fifoFull;
    logic fifoPush;
    logic fifoPop;

    // Address decode, handshake, FIFO control and read-data selection for the current request
    always_comb begin
        tohostHit     = (req_addr_i == TOHOST_ADDR);
        fromhostHit   = (req_addr_i == FROMHOST_ADDR);
        // Only a tohost store is held off, and only while a command is still in flight;
        // in HALT such stores are accepted and simply dropped
        req_rdy_o     = !(((state_q == CONS) || (state_q == ACK)) && req_we_i && tohostHit);
        reqAccept     = req_vld_i && req_rdy_o;
        tohostWrite   = reqAccept && req_we_i && tohostHit && (state_q == IDLE);
        fromhostWrite = reqAccept && req_we_i && fromhostHit;
        isPutchar     = (req_wdata_i[63:56] == 8'h01) && (req_wdata_i[55:48] == 8'h01);
        fifoEmpty     = (count_q == '0);
        fifoFull      = (count_q == FIFO_FULL_CNT);
        fifoPop       = !fifoEmpty && con_rdy_i;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the character
        fifoPush      = (state_q == CONS) && (!fifoFull || fifoPop);
        rsp_rdata_d   = 64'h0;
        if (reqAccept && !req_we_i) begin
            if (tohostHit) begin
                rsp_rdata_d = tohost_q;
            end else if (fromhostHit) begin
                rsp_rdata_d = fromhost_q;
            end
        end
        count_d = count_q;
        case ({fifoPush, fifoPop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // One-cycle response pulse for every accepted request, carrying read data sampled at acceptance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_vld_q   <= 1'b0;
            rsp_rdata_q <= 64'h0;
        end else begin
            rsp_vld_q   <= reqAccept;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Command FSM: captures tohost, decodes it, owns the exit status and the fromhost acknowledge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            tohost_q    <= 64'h0;
            fromhost_q  <= 64'h0;
            halt_q      <= 1'b0;
            pass_q      <= 1'b0;
            exit_code_q <= 63'h0;
        end else begin
            if (fromhostWrite) begin
                fromhost_q <= req_wdata_i;
            end
            case (state_q)
                IDLE: begin
                    if (tohostWrite) begin
                        tohost_q <= req_wdata_i;
                        // Console commands carry arbitrary character bytes, odd ones included,
                        // so the putchar pattern is recognised ahead of the exit bit
                        if (req_wdata_i == 64'h0) begin
                            state_q <= IDLE;
                        end else if (isPutchar) begin
                            state_q <= CONS;
                        end else if (req_wdata_i[0]) begin
                            state_q     <= HALT;
                            halt_q      <= 1'b1;
                            pass_q      <= (req_wdata_i == 64'h1);
                            exit_code_q <= req_wdata_i[63:1];
                        end else begin
                            state_q <= ACK;
                        end
                    end
                end
                CONS: begin
                    if (fifoPush) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    // The acknowledge overrides a same-cycle bus write to fromhost
                    fromhost_q <= {tohost_q[63:48], 48'h1};
                    tohost_q   <= 64'h0;
                    state_q    <= IDLE;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Console character FIFO; storage is reset so the head reads 0 when idle after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 8'h0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifoPush) begin
                fifo_mem_q[wr_ptr_q] <= tohost_q[7:0];
                wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
            end
            if (fifoPop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    assign rsp_vld_o   = rsp_vld_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign con_vld_o   = !fifoEmpty;
    assign con_char_o  = fifo_mem_q[rd_ptr_q];
    assign halt_o      = halt_q;
    assign pass_o      = pass_q;
    assign exit_code_o = exit_code_q;

endmodule

// File: tb/tb_sy_htif_responder.sv
// tb_sy_htif_responder
// Directed scenarios with literal expectations, followed by randomized bus and console traffic.
// A queue-based behavioural model of the responder is checked against the DUT on every cycle.
module tb_sy_htif_responder;

   localparam logic [63:0] TOHOST     = 64'h8000_1000;
   localparam logic [63:0] FROMHOST   = 64'h8000_1040;
   localparam int          FIFO_DEPTH = 4;

   logic        clock;
   logic        reset;
   logic        reqVld;
   logic        reqWe;
   logic [63:0] reqAddr;
   logic [63:0] reqWdata;
   logic        conRdy;

   logic        req_rdy_o;
   logic        rsp_vld_o;
   logic [63:0] rsp_rdata_o;
   logic        con_vld_o;
   logic [7:0]  con_char_o;
   logic        halt_o;
   logic        pass_o;
   logic [62:0] exit_code_o;

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 0;

   // Behavioural model state
   logic [63:0] mTohost;
   logic [63:0] mFromhost;
   logic [7:0]  mQueue[$];
   logic        mHalted;
   logic        mPass;
   logic [62:0] mExit;
   logic        mRspVld;
   logic [63:0] mRspData;
   int          mBusy;   // 0 free, 1 character waiting for room, 2 acknowledge pending

   sy_htif_responder dut (
      .clk_i       (clock),
      .rst_i       (reset),
      .req_vld_i   (reqVld),
      .req_rdy_o   (req_rdy_o),
      .req_we_i    (reqWe),
      .req_addr_i  (reqAddr),
      .req_wdata_i (reqWdata),
      .rsp_vld_o   (rsp_vld_o),
      .rsp_rdata_o (rsp_rdata_o),
      .con_vld_o   (con_vld_o),
      .con_char_o  (con_char_o),
      .con_rdy_i   (conRdy),
      .halt_o      (halt_o),
      .pass_o      (pass_o),
      .exit_code_o (exit_code_o)
   );

   // Free-running clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   function automatic logic modelRdy();
      return !((mBusy != 0) && reqWe && (reqAddr == TOHOST));
   endfunction

   task automatic modelStep();
      logic        pop;
      logic        acc;
      logic [63:0] oldTohost;
      int          wasBusy;
      if (reset) begin
         mTohost   = 0;
         mFromhost = 0;
         mQueue.delete();
         mHalted   = 0;
         mPass     = 0;
         mExit     = 0;
         mRspVld   = 0;
         mRspData  = 0;
         mBusy     = 0;
         return;
      end
      pop      = (mQueue.size() > 0) && conRdy;
      acc      = reqVld && modelRdy();
      mRspVld  = acc;
      mRspData = 0;
      if (acc && !reqWe) begin
         if (reqAddr == TOHOST) mRspData = mTohost;
         else if (reqAddr == FROMHOST) mRspData = mFromhost;
      end
      oldTohost = mTohost;
      wasBusy   = mBusy;
      if (pop) void'(mQueue.pop_front());
      if (acc && reqWe && reqAddr == FROMHOST) mFromhost = reqWdata;
      if (wasBusy == 1) begin
         if (mQueue.size() < FIFO_DEPTH) begin
            mQueue.push_back(oldTohost[7:0]);
            mBusy = 2;
         end
      end else if (wasBusy == 2) begin
         mFromhost = {oldTohost[63:48], 48'h1};
         mTohost   = 0;
         mBusy     = 0;
      end else if (acc && reqWe && reqAddr == TOHOST && !mHalted) begin
         mTohost = reqWdata;
         if (reqWdata == 0) begin
            mBusy = 0;
         end else if (reqWdata[63:48] == 16'h0101) begin
            mBusy = 1;
         end else if (reqWdata[0]) begin
            mHalted = 1;
            mPass   = (reqWdata == 64'h1);
            mExit   = reqWdata[63:1];
         end else begin
            mBusy = 2;
         end
      end
   endtask

   // Advance the model at every active edge using the inputs the DUT sees
   initial begin
      forever begin
         @(posedge clock);
         modelStep();
      end
   end

   // Compare every DUT output against the model away from the active edge
   initial begin
      forever begin
         @(negedge clock);
         if (checkEn) begin
            checkOutput("mdlReqRdy", req_rdy_o, modelRdy());
            checkOutput("mdlRspVld", rsp_vld_o, mRspVld);
            checkOutput("mdlRspData", rsp_rdata_o, mRspData);
            checkOutput("mdlConVld", con_vld_o, mQueue.size() > 0);
            if (mQueue.size() > 0) checkOutput("mdlConChar", con_char_o, mQueue[0]);
            checkOutput("mdlHalt", halt_o, mHalted);
            checkOutput("mdlPass", pass_o, mPass);
            checkOutput("mdlExit", exit_code_o, mExit);
         end
      end
   end

   task automatic doReset();
      @(posedge clock); #1;
      reset  = 1;
      reqVld = 0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 0;
   endtask

   task automatic doReq(input logic we, input logic [63:0] addr, input logic [63:0] data);
      @(posedge clock); #1;
      reqVld   = 1;
      reqWe    = we;
      reqAddr  = addr;
      reqWdata = data;
      for (int c = 0; c < 50; c++) begin
         @(negedge clock);
         if (req_rdy_o) break;
      end
      checkOutput("reqAccepted", req_rdy_o, 1);
      @(posedge clock); #1;
      reqVld   = 0;
      reqWe    = 0;
      reqWdata = 0;
   endtask

   task automatic readCheck(input string name, input logic [63:0] addr, input logic [63:0] expected);
      doReq(0, addr, 64'h0);
      @(negedge clock);
      checkOutput({name, "Vld"}, rsp_vld_o, 1);
      checkOutput(name, rsp_rdata_o, expected);
   endtask

   task automatic fillAndStall(input bit clearFromhost);
      logic [63:0] cmd;
      conRdy = 0;
      for (int i = 0; i < 5; i++) begin
         cmd = {16'h0101, 40'h0, 8'h61 + 8'(i)};
         doReq(1, TOHOST, cmd);
         if (i < 4) begin
            repeat (3) @(posedge clock);
            if (clearFromhost) doReq(1, FROMHOST, 64'h0);
         end
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      checkOutput("fullConVld", con_vld_o, 1);
      checkOutput("fullHeadA", con_char_o, 8'h61);
   endtask

   task automatic applyStimulus();
      int sel;
      @(posedge clock); #1;
      reset  = ($urandom_range(0, mHalted ? 19 : 149) == 0);
      reqVld = ($urandom_range(0, 9) < 6);
      reqWe  = ($urandom_range(0, 9) < 6);
      conRdy = $urandom_range(0, 1);
      sel    = $urandom_range(0, 99);
      if (sel < 45) reqAddr = TOHOST;
      else if (sel < 80) reqAddr = FROMHOST;
      else reqAddr = {32'h8000_0000, ($urandom & 32'hffff_fff8)};
      sel = $urandom_range(0, 99);
      if (sel < 40) reqWdata = {16'h0101, 8'($urandom), 32'($urandom), 8'($urandom)};
      else if (sel < 52) reqWdata = 64'h0;
      else if (sel < 67) reqWdata = {8'($urandom_range(2, 255)), 24'($urandom), 32'($urandom)} & ~64'h1;
      else if (sel < 70) reqWdata = {32'($urandom), 32'($urandom)} | 64'h1;
      else reqWdata = {32'($urandom), 32'($urandom)} & ~64'h1;
   endtask

   // Directed scenarios followed by randomized traffic
   initial begin
      logic [7:0] got[$];
      reset    = 1;
      reqVld   = 0;
      reqWe    = 0;
      reqAddr  = 0;
      reqWdata = 0;
      conRdy   = 0;
      @(posedge clock); #1;
      checkEn = 1;
      doReset();

      // Reset state
      @(negedge clock);
      checkOutput("rstHalt", halt_o, 0);
      checkOutput("rstPass", pass_o, 0);
      checkOutput("rstExit", exit_code_o, 0);
      checkOutput("rstRspVld", rsp_vld_o, 0);
      checkOutput("rstRspData", rsp_rdata_o, 0);
      checkOutput("rstConVld", con_vld_o, 0);
      checkOutput("rstConChar", con_char_o, 0);
      checkOutput("rstReqRdy", req_rdy_o, 1);

      // Pass exit, then a discarded tohost write
      doReq(1, TOHOST, 64'h1);
      @(negedge clock);
      checkOutput("passHalt", halt_o, 1);
      checkOutput("passPass", pass_o, 1);
      checkOutput("passExit", exit_code_o, 0);
      doReq(1, TOHOST, 64'h3);
      @(negedge clock);
      checkOutput("passHaltKept", halt_o, 1);
      checkOutput("passPassKept", pass_o, 1);
      checkOutput("passExitKept", exit_code_o, 0);
      readCheck("passTohost", TOHOST, 64'h1);
      doReset();

      // Fail exit
      doReq(1, TOHOST, 64'hB);
      @(negedge clock);
      checkOutput("failHalt", halt_o, 1);
      checkOutput("failPass", pass_o, 0);
      checkOutput("failExit", exit_code_o, 5);
      readCheck("failTohost", TOHOST, 64'hB);
      doReset();

      // Single putchar with the sink ready
      conRdy = 1;
      doReq(1, TOHOST, 64'h0101_0000_0000_0041);
      @(negedge clock);
      checkOutput("putN1ConVld", con_vld_o, 0);
      @(negedge clock);
      checkOutput("putN2ConVld", con_vld_o, 1);
      checkOutput("putN2ConChar", con_char_o, 8'h41);
      readCheck("putFromhost", FROMHOST, 64'h0101_0000_0000_0001);
      readCheck("putTohost", TOHOST, 64'h0);
      doReq(1, FROMHOST, 64'h0);

      // Backpressure: four buffered, the fifth stalls
      fillAndStall(1);
      @(posedge clock); #1;
      reqVld   = 1;
      reqWe    = 1;
      reqAddr  = TOHOST;
      reqWdata = 64'h0101_0000_0000_0066;
      @(negedge clock);
      checkOutput("stallReqRdy", req_rdy_o, 0);
      @(posedge clock); #1;
      reqVld   = 0;
      reqWe    = 0;
      reqWdata = 0;
      conRdy   = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (con_vld_o) got.push_back(con_char_o);
      end
      checkOutput("drainCount", got.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) checkOutput("drainChar", got[i], 8'h61 + 8'(i));
      end
      readCheck("fifthAck", FROMHOST, 64'h0101_0000_0000_0001);
      readCheck("fifthTohost", TOHOST, 64'h0);

      // Unmapped address and unknown command
      doReq(1, 64'h8000_2000, 64'hDEAD_BEEF);
      readCheck("unmappedRead", 64'h8000_2000, 64'h0);
      doReq(1, TOHOST, 64'h0200_0000_0000_0000);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checkOutput("unknownNoChar", con_vld_o, 0);
      end
      readCheck("unknownAck", FROMHOST, 64'h0200_0000_0000_0001);

      // Reset while stalled in CONS with a full FIFO
      fillAndStall(0);
      doReset();
      @(negedge clock);
      checkOutput("midRstConVld", con_vld_o, 0);
      checkOutput("midRstConChar", con_char_o, 0);
      checkOutput("midRstHalt", halt_o, 0);
      checkOutput("midRstRspVld", rsp_vld_o, 0);
      readCheck("midRstTohost", TOHOST, 64'h0);
      readCheck("midRstFromhost", FROMHOST, 64'h0);

      // Randomized traffic checked by the model
      doReset();
      for (int n = 0; n < 3000; n++) applyStimulus();
      @(posedge clock); #1;
      reset  = 0;
      reqVld = 0;
      conRdy = 1;
      repeat (10) @(posedge clock);
      @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
